// File: rtl/sdram_wrgen.sv
// sdram_wrgen: SDRAM write-pattern generator with read-side address tracking.
//   After a power-up wait it writes one pass of (ADDR_END+1) bursts into the
//   SDRAM write FIFO, one burst per PERIOD-cycle slot. It then follows the
//   controller's read acknowledges until a restart pulse requests a new pass.
// Ports:
//   clk_100m      in   clock
//   rst_n         in   synchronous active-low reset
//   mode[1:0]     in   data source: 0 datain, 1 increment, 2 address tag, 3 PATTERN
//   datain[DW]    in   external data word
//   sdram_rd_ack  in   asynchronous read acknowledge (synchronized internally)
//   restart       in   one-cycle pulse, starts a new write pass from the read state
//   wrf_wrreq     out  write-FIFO write request
//   wrf_din[DW]   out  write-FIFO data
//   moni_addr     out  {burst address, LB'b0}
//   syswr_done    out  write pass complete
//   word_idx[LB]  out  index of the current word within the burst
//   rd_wrap       out  one-cycle pulse when the read address wraps to 0
module sdram_wrgen #(
   parameter int unsigned DW       = 16,
   parameter int unsigned AW       = 19,
   parameter int unsigned BURST    = 8,
   parameter int unsigned ADDR_END = 3,
   parameter int unsigned PERIOD   = 64,
   parameter int unsigned OFFSET   = 5,
   parameter int unsigned DELAY    = 50000,
   parameter logic [DW-1:0] PATTERN = DW'(16'h6211),
   localparam int unsigned LB      = $clog2(BURST)
) (
   input  logic             clk_100m,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [DW-1:0]    datain,
   input  logic             sdram_rd_ack,
   input  logic             restart,
   output logic             wrf_wrreq,
   output logic [DW-1:0]    wrf_din,
   output logic [AW+LB-1:0] moni_addr,
   output logic             syswr_done,
   output logic [LB-1:0]    word_idx,
   output logic             rd_wrap
);

   localparam int unsigned SW  = $clog2(PERIOD);
   localparam int unsigned DLW = $clog2(DELAY + 1);

   typedef enum logic [1:0] {
      ST_PWR = 2'd0,
      ST_WR  = 2'd1,
      ST_RD  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [DLW-1:0]  r_delay;
   logic [SW-1:0]   r_slot;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_inc;
   logic            r_ack_s1;
   logic            r_ack_s2;
   logic            r_ack_d;
   logic            r_wrreq;
   logic [DW-1:0]   r_din;
   logic [LB-1:0]   r_idx;
   logic            r_done;
   logic            r_wrap;

   logic            w_ack_fall;
   logic            w_addr_last;
   logic [LB-1:0]   w_idx;
   logic [DW-1:0]   w_din;
   logic            w_in_burst;
   logic            w_slot_end;
   logic            w_pass_end;
   logic            w_rd_step;
   logic            w_rd_wrap;
   logic            w_restart;

   // Falling edge of the synchronized read acknowledge
   assign w_ack_fall  = r_ack_d & ~r_ack_s2;
   assign w_addr_last = (r_addr == AW'(ADDR_END));
   assign w_idx       = LB'(r_slot - SW'(OFFSET));

   // Data source for the word sampled on this edge
   always_comb begin
      w_din = PATTERN;
      case (mode)
         2'd0:    w_din = datain;
         2'd1:    w_din = r_inc;
         2'd2:    w_din = DW'({r_addr, w_idx});
         default: w_din = PATTERN;
      endcase
   end

   // State register
   always_ff @(posedge clk_100m) begin
      if (!rst_n) r_state <= ST_PWR;
      else        r_state <= w_state_nxt;
   end

   // Next state and control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_in_burst  = 1'b0;
      w_slot_end  = 1'b0;
      w_pass_end  = 1'b0;
      w_rd_step   = 1'b0;
      w_rd_wrap   = 1'b0;
      w_restart   = 1'b0;
      case (r_state)
         ST_PWR: begin
            if (r_delay == DLW'(DELAY - 1)) w_state_nxt = ST_WR;
         end
         ST_WR: begin
            w_in_burst = (r_slot >= SW'(OFFSET)) && (r_slot < SW'(OFFSET + BURST));
            w_slot_end = (r_slot == SW'(PERIOD - 1));
            if (w_slot_end && w_addr_last) begin
               w_pass_end  = 1'b1;
               w_state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            // restart takes priority over a coincident acknowledge edge
            if (restart) begin
               w_restart   = 1'b1;
               w_state_nxt = ST_WR;
            end else if (w_ack_fall) begin
               w_rd_step = 1'b1;
               w_rd_wrap = w_addr_last;
            end
         end
         default: w_state_nxt = ST_PWR;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_100m) begin
      if (!rst_n) begin
         r_delay  <= '0;
         r_slot   <= '0;
         r_addr   <= '0;
         r_inc    <= '0;
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
         r_ack_d  <= 1'b0;
         r_wrreq  <= 1'b0;
         r_din    <= PATTERN;
         r_idx    <= '0;
         r_done   <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_ack_s1 <= sdram_rd_ack;
         r_ack_s2 <= r_ack_s1;
         r_ack_d  <= r_ack_s2;
         r_wrap   <= w_rd_wrap;
         r_wrreq  <= w_in_burst;

         if (r_state == ST_PWR) r_delay <= r_delay + DLW'(1);

         // Slot counter only runs during the write pass; power of two wraps naturally
         r_slot <= (r_state == ST_WR) ? r_slot + SW'(1) : '0;

         if (w_in_burst) begin
            r_din <= w_din;
            r_idx <= w_idx;
            if (mode == 2'd1) r_inc <= r_inc + DW'(1);
         end
         if (w_restart) r_inc <= '0;

         if (w_restart || w_pass_end || w_rd_wrap) r_addr <= '0;
         else if (w_slot_end || w_rd_step)          r_addr <= r_addr + AW'(1);

         if (w_pass_end)     r_done <= 1'b1;
         else if (w_restart) r_done <= 1'b0;
      end
   end

   assign wrf_wrreq  = r_wrreq;
   assign wrf_din    = r_din;
   assign moni_addr  = {r_addr, {LB{1'b0}}};
   assign syswr_done = r_done;
   assign word_idx   = r_idx;
   assign rd_wrap    = r_wrap;

endmodule

// File: doc/sdram_wrgen.md
SDRAM_WRGEN -- requirements
Module: sdram_wrgen

Interface
REQ-001 SHALL have parameter DW, default 16, data word width.
REQ-002 SHALL have parameter AW, default 19, burst address counter width.
REQ-003 SHALL have parameter BURST, default 8, words per burst (power of two, 2..64); LB = log2(BURST).
REQ-004 SHALL have parameter ADDR_END, default 3, last burst address written.
REQ-005 SHALL have parameter PERIOD, default 64, slot length in cycles (power of two, >= OFFSET+BURST+2).
REQ-006 SHALL have parameter OFFSET, default 5, slot cycle of the first write request.
REQ-007 SHALL have parameter DELAY, default 50000, power-up wait in cycles.
REQ-008 SHALL have parameter PATTERN, default DW'h6211, fixed-mode data word.
REQ-009 SHALL have port clk_100m, input, 1, the only clock.
REQ-010 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk_100m.
REQ-011 SHALL have port mode, input, 2, data source: 0 datain, 1 increment, 2 address tag, 3 PATTERN.
REQ-012 SHALL have port datain, input, DW, external data.
REQ-013 SHALL have port sdram_rd_ack, input, 1, asynchronous read-acknowledge from the SDRAM controller.
REQ-014 SHALL have port restart, input, 1, single-cycle pulse requesting a new write pass.
REQ-015 SHALL have port wrf_wrreq, output, 1, write-FIFO write request.
REQ-016 SHALL have port wrf_din, output, DW, write-FIFO data.
REQ-017 SHALL have port moni_addr, output, AW+LB, equal to {addr, LB'b0}.
REQ-018 SHALL have port syswr_done, output, 1, write pass complete.
REQ-019 SHALL have port word_idx, output, LB, index of the current word within the burst.
REQ-020 SHALL have port rd_wrap, output, 1, one-cycle pulse on read-address wrap.

Function
REQ-021 SHALL implement states PWR (power-up wait), WR (write pass), RD (read tracking).
REQ-022 PWR: delay counter increments to DELAY, then state goes to WR with slot counter = 0.
REQ-023 WR: slot counter increments every cycle and wraps from PERIOD-1 to 0.
REQ-024 WR: wrf_wrreq is 1 exactly for slot cycles OFFSET .. OFFSET+BURST-1 (BURST cycles), else 0.
REQ-025 wrf_din and word_idx are registered on the same edge as wrf_wrreq; word_idx runs 0..BURST-1 within each burst.
REQ-026 Data by mode, sampled per word: 0 -> datain of that cycle; 1 -> running counter, +1 per word, starting at 0 after reset/restart and wrapping modulo 2^DW; 2 -> {addr, word_idx} truncated or zero-extended to DW; 3 -> PATTERN.
REQ-027 A mode change takes effect on the next word; no word is dropped or duplicated.
REQ-028 WR, slot == PERIOD-1: if addr == ADDR_END, then syswr_done <= 1, addr <= 0, state <= RD; otherwise addr <= addr+1.
REQ-029 sdram_rd_ack SHALL pass through a two-flop synchronizer; a falling edge is detected on the synchronized signal.
REQ-030 RD, falling edge: addr <= addr+1; if addr == ADDR_END, addr <= 0 and rd_wrap = 1 for one cycle.
REQ-031 Falling edges SHALL be ignored in PWR and WR.
REQ-032 RD, restart = 1: syswr_done <= 0, addr <= 0, slot <= 0, increment counter <= 0, state <= WR.
REQ-033 restart SHALL be ignored in PWR and WR.
REQ-034 If restart and a falling edge occur in the same RD cycle, restart wins and addr = 0.
REQ-035 wrf_wrreq SHALL never be 1 in PWR or RD.

Reset
REQ-036 When rst_n = 0 at a clock edge, on that edge: state = PWR, delay = 0, slot = 0, addr = 0, both synchronizer flops = 0, increment counter = 0, wrf_wrreq = 0, wrf_din = PATTERN, word_idx = 0, syswr_done = 0, rd_wrap = 0.
REQ-037 A reset asserted mid-burst SHALL clear wrf_wrreq on the same edge; no partial burst resumes after reset.

Verification
REQ-038 Default parameters, mode 3, reset release: first wrf_wrreq occurs at cycle DELAY+OFFSET (+/-1 registration cycle, fixed by the implementation), high 8 cycles with data 6211; 4 bursts total, moni_addr 0, 8, 16, 24; syswr_done rises after the 4th slot.
REQ-039 mode 1: the 32 words of the pass are 0..31 in order, with word_idx cycling 0..7.
REQ-040 mode 2, DW=16, AW=19, BURST=8: word 5 of burst addr 2 is 0x0015.
REQ-041 In RD, four falling edges of sdram_rd_ack: addr 1, 2, 3, 0; rd_wrap pulses once, on the 4th edge; edges are ignored during WR.
REQ-042 In RD, restart together with a rd_ack falling edge: addr = 0, syswr_done = 0, and the new pass starts identically to the first.
REQ-043 Reset at the 3rd word of a burst: wrf_wrreq = 0 on the next edge and the full power-up sequence repeats.
